audio_mix_sequencer: RTL

- Time-multiplexed stereo mixer engine that replaces the parallel adder tree with one multiply-accumulate path.
- On each sample tick, a FSM snapshots all sound sources, then walks the channels one per clock, applying per-channel 4-bit volume and L/R pan. It emits saturated 9-bit stereo samples with a valid strobe.
- Per-channel settings are CPU-configurable through an index/data I/O port pair. It sits between the sound sources (AY x2, beeper, specdrum) and the audio output/DAC stage.

---
 rtl/audio_mix_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/audio_mix_sequencer.sv
// audio_mix_sequencer: time-multiplexed stereo mixer.
// On a sample tick it snapshots all sources and channel settings, then runs one
// multiply-accumulate per clock over NCH channels. The result is a saturated
// 9-bit left/right sample with a one-clock valid strobe.
// The channel registers are reached through an index/data I/O port pair.
// Optional feature: define AUDIOSEQ_AUTOINC_EN so that each data-port access
// advances the index register.
module audio_mix_sequencer #(
    parameter int         NCH        = 8,
    parameter logic [7:0] INDEX_PORT = 8'hF4,
    parameter logic [7:0] DATA_PORT  = 8'hF5
) (
    input  logic               clk,
    input  logic               mrst_n,
    input  logic [7:0]         a,
    input  logic               iorq_n,
    input  logic               rd_n,
    input  logic               wr_n,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               oe,
    input  logic               sample_tick,
    input  logic [8*NCH-1:0]   src_bus,
    output logic [8:0]         output_left,
    output logic [8:0]         output_right,
    output logic               sample_valid,
    output logic               busy
);

    localparam int         CW         = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [3:0] STATUS_IDX = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    state_t         state, state_nxt;

    logic [7:0]     chreg    [NCH];
    logic [7:0]     snap_src [NCH];
    logic [7:0]     snap_reg [NCH];
    logic [3:0]     index;
    logic           overrun;
    logic [CW-1:0]  ch;
    logic [14:0]    acc_l, acc_r;
    logic           io_wr_q, io_rd_q;

    logic           io_wr, wr_first, rd_first;
    logic           idx_wr, data_wr, idx_valid;
    logic [CW-1:0]  idx_sel;
    logic           snap_en, acc_en, out_en, tick_drop;
    logic [7:0]     cur_src, cur_reg;
    logic [11:0]    prod;

    // Power-on settings: AY channel A left, B right, C centre; beeper/specdrum centre.
    function automatic logic [7:0] chreg_reset(input int n);
        if (n >= 6) return 8'hCF;
        case (n % 3)
            0:       return 8'h8F;
            1:       return 8'h4F;
            default: return 8'hCF;
        endcase
    endfunction

    // Saturate a 15-bit accumulator (scaled by 1/32) to the 9-bit output range.
    function automatic logic [8:0] saturate(input logic [14:0] acc);
        return (acc[14:5] > 10'd511) ? 9'd511 : acc[13:5];
    endfunction

    // I/O decode; register side effects fire on the first clock of each bus cycle.
    assign io_wr     = !iorq_n && !wr_n;
    assign oe        = (a == DATA_PORT) && !iorq_n && !rd_n;
    assign wr_first  = io_wr && !io_wr_q;
    assign rd_first  = oe && !io_rd_q;
    assign idx_wr    = wr_first && (a == INDEX_PORT);
    assign data_wr   = wr_first && (a == DATA_PORT);
    assign idx_valid = ({28'd0, index} < 32'(NCH));
    assign idx_sel   = index[CW-1:0];

    // Read data mux: channel register, status word, or zero.
    always_comb begin
        dout = 8'h00;
        if (idx_valid)
            dout = chreg[idx_sel];
        else if (index == STATUS_IDX)
            dout = {6'b0, overrun, busy};
    end

    // Sequencer next-state and one-hot control strobes.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_nxt = state;
        snap_en   = 1'b0;
        acc_en    = 1'b0;
        out_en    = 1'b0;
        tick_drop = 1'b0;
        case (state)
            S_IDLE: begin
                if (sample_tick) begin
                    snap_en   = 1'b1;
                    state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                acc_en    = 1'b1;
                tick_drop = sample_tick;
                if (ch == CW'(NCH - 1))
                    state_nxt = S_OUT;
            end
            S_OUT: begin
                out_en    = 1'b1;
                tick_drop = sample_tick;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!mrst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Snapshot of sources and settings taken at the start of each sequence.
    always_ff @(posedge clk) begin
        // NOTE: the shadow copies carry no reset; they are always reloaded before the accumulator reads them.
        if (snap_en) begin
            for (int i = 0; i < NCH; i++) begin
                snap_src[i] <= src_bus[8*i +: 8];
                snap_reg[i] <= chreg[i];
            end
        end
    end

    // Single shared multiplier for the current channel.
    assign cur_src = snap_src[ch];
    assign cur_reg = snap_reg[ch];
    assign prod    = 12'(cur_src) * 12'(cur_reg[3:0]);

    // Accumulator, channel walk and output registers.
    always_ff @(posedge clk) begin
        if (!mrst_n) begin
            acc_l        <= '0;
            acc_r        <= '0;
            ch           <= '0;
            busy         <= 1'b0;
            output_left  <= '0;
            output_right <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (snap_en) begin
                acc_l <= '0;
                acc_r <= '0;
                ch    <= '0;
                busy  <= 1'b1;
            end
            if (acc_en) begin
                if (cur_reg[7]) acc_l <= acc_l + 15'(prod);
                if (cur_reg[6]) acc_r <= acc_r + 15'(prod);
                if (ch != CW'(NCH - 1))
                    ch <= ch + 1'b1;
            end
            if (out_en) begin
                output_left  <= saturate(acc_l);
                output_right <= saturate(acc_r);
                sample_valid <= 1'b1;
                busy         <= 1'b0;
            end
        end
    end

    // CPU-visible registers: index, channel settings, overrun flag.
    always_ff @(posedge clk) begin
        if (!mrst_n) begin
            index   <= '0;
            overrun <= 1'b0;
            io_wr_q <= 1'b0;
            io_rd_q <= 1'b0;
            for (int i = 0; i < NCH; i++)
                chreg[i] <= chreg_reset(i);
        end else begin
            io_wr_q <= io_wr;
            io_rd_q <= oe;
            if (idx_wr)
                index <= din[3:0];
            if (data_wr && idx_valid)
                chreg[idx_sel] <= din & 8'hCF;
`ifdef AUDIOSEQ_AUTOINC_EN
            if (data_wr || rd_first)
                index <= (index >= STATUS_IDX) ? 4'd0 : index + 4'd1;
`endif
            // A dropped tick in the same clock as a status read must not be lost.
            if (tick_drop)
                overrun <= 1'b1;
            else if (rd_first && (index == STATUS_IDX))
                overrun <= 1'b0;
        end
    end

endmodule
